frv_wb_arb: RTL and testbench
=============================

// Module: frv_wb_arb
// PURPOSE
//  Two-master to one-slave Wishbone classic arbiter sitting directly below the FazyRV core macro.
//  Merges the core's instruction bus (imem) and data bus (dmem) onto one shared memory/peripheral bus.
//  Alternating priority prevents starvation. A per-transfer watchdog frees the core if the slave never acks.
// PARAMETERS
//  TIMEOUT   64            cycles a granted transfer may wait for ack_i; 0 disables the watchdog
//  ERR_DATA  32'h0000_0013 read data returned on timeout (NOP encoding, harmless on imem)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_in         in   1   asynchronous reset, active low
//  wb_imem_cyc_i  in   1   imem cycle from core
//  wb_imem_stb_i  in   1   imem strobe from core
//  wb_imem_adr_i  in   32  imem address
//  wb_imem_dat_o  out  32  imem read data
//  wb_imem_ack_o  out  1   imem acknowledge
//  wb_dmem_cyc_i  in   1   dmem cycle from core
//  wb_dmem_stb_i  in   1   dmem strobe from core
//  wb_dmem_we_i   in   1   dmem write enable
//  wb_dmem_be_i   in   4   dmem byte enables
//  wb_dmem_adr_i  in   32  dmem address
//  wb_dmem_dat_i  in   32  dmem write data
//  wb_dmem_dat_o  out  32  dmem read data
//  wb_dmem_ack_o  out  1   dmem acknowledge
//  wb_mem_cyc_o   out  1   shared bus cycle
//  wb_mem_stb_o   out  1   shared bus strobe
//  wb_mem_we_o    out  1   shared bus write enable (0 for imem)
//  wb_mem_be_o    out  4   shared bus byte enables (4'hF for imem)
//  wb_mem_adr_o   out  32  shared bus address
//  wb_mem_dat_o   out  32  shared bus write data (0 for imem)
//  wb_mem_dat_i   in   32  shared bus read data
//  wb_mem_ack_i   in   1   shared bus acknowledge
//  timeout_o      out  1   one-cycle pulse when the watchdog terminates a transfer
// BEHAVIOUR
//  - Reset: state IDLE, last_dmem=0; all outputs 0.
//  - Request: req_x = cyc_i & stb_i.
//  - FSM states IDLE, GNT_I, GNT_D; the grant is registered.
//  - IDLE: both requesting -> grant the master not served last (first arbitration after reset: dmem);
//    one requesting -> grant it. None -> stay.
//  - Latency: a request seen in IDLE at cycle n drives wb_mem_cyc/stb high at cycle n+1.
//  - Grant state: the granted master's signals are muxed combinationally onto wb_mem_*; cyc_o = stb_o = 1.
//  - Read data: wb_mem_dat_i feeds both dat_o; only the granted master's ack_o follows wb_mem_ack_i,
//    combinationally.
//  - Completion: on wb_mem_ack_i -> IDLE and update last_dmem. At least one idle bus cycle separates transfers.
//  - Abort: granted master drops cyc_i -> IDLE next cycle. wb_mem_cyc_o falls in that same cycle, since the
//    mux is gated by master cyc. No ack is generated.
//  - Stray ack: wb_mem_ack_i in IDLE is ignored; both ack_o stay 0.
//  - Watchdog: counter cleared on grant entry, +1 per grant cycle without ack. At count == TIMEOUT-1 with
//    no ack the arbiter does all of the following in that cycle:
//      * asserts the granted ack_o
//      * drives that master's dat_o = ERR_DATA
//      * pulses timeout_o
//      * deasserts wb_mem_cyc/stb
//    It then returns to IDLE.
//  - Real ack in the same cycle as expiry wins: no timeout_o, real data returned.
//  - Counter width $clog2(TIMEOUT+1); it saturates and never wraps.
//  - Async reset mid-transfer: immediate IDLE, outputs 0; any slave ack arriving afterwards is ignored.
// STRUCTURE
//  - frv_wb_arb_pkg: typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_t; localparam IMEM_BE = 4'hF.
//  - Sub-module frv_wb_wdog: counter with clr/en inputs and an expire output, parameterised by TIMEOUT.
//  - Top contains the FSM and the output muxes.
// TESTING
//  - imem-only read: imem req adr 0x40, slave acks on 3rd cycle with 0x00000093
//    -> imem_ack 1 cycle, dat 0x93, wb_mem_be_o=F, we=0.
//  - Simultaneous req after reset: dmem write 0x100/0xDEADBEEF/be=3 granted first;
//    imem granted next, with exactly one idle cycle between the two wb_mem_cyc_o high periods.
//  - Back-to-back contention: both masters re-request continuously for 6 transfers
//    -> strict alternation D,I,D,I,D,I.
//  - Timeout, TIMEOUT=4, slave never acks: dmem read -> dmem_ack in 4th grant cycle, dat 0x00000013,
//    timeout_o single pulse, wb_mem_cyc_o low next cycle.
//  - Ack at expiry: slave acks exactly in the 4th grant cycle with 0xA5A5A5A5
//    -> data 0xA5A5A5A5, timeout_o stays 0.
//  - Reset and abort: rst_in low during a grant -> all outputs 0 asynchronously, later stray ack ignored;
//    separately, imem drops cyc mid-grant -> no ack, state IDLE.

Source files
------------

// File: rtl/frv_wb_arb_pkg.sv
// Shared types and helpers for the FazyRV two-master Wishbone arbiter.
// Grant selection lives here so the arbitration rule is stated once.
package frv_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] IMEM_BE = 4'hF;

  // Contention goes to the master not served last; a lone requester always wins.
  function automatic arb_state_t pick_grant(input logic req_i, input logic req_d,
                                            input logic last_dmem);
    arb_state_t g;
    if (req_i && req_d) begin
      g = last_dmem ? GNT_I : GNT_D;
    end else if (req_d) begin
      g = GNT_D;
    end else if (req_i) begin
      g = GNT_I;
    end else begin
      g = IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/frv_wb_wdog.sv
// Per-transfer watchdog: counts grant cycles without ack and flags the last allowed one.
// A TIMEOUT of 0 disables expiry entirely.
module frv_wb_wdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          ARMED = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] cnt_r;

  // Saturating grant-cycle counter, held at zero outside a grant.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry is combinational so the arbiter can terminate in the same cycle.
  always_comb begin
    expire = ARMED & en & (cnt_r == LAST);
  end

endmodule

// File: rtl/frv_wb_arb.sv
// Two-master (imem/dmem) to one-slave Wishbone classic arbiter below the FazyRV core.
// Alternating priority on contention; a watchdog terminates transfers the slave never acks.
module frv_wb_arb
  import frv_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_imem_cyc_i,
  input  logic        wb_imem_stb_i,
  input  logic [31:0] wb_imem_adr_i,
  output logic [31:0] wb_imem_dat_o,
  output logic        wb_imem_ack_o,
  input  logic        wb_dmem_cyc_i,
  input  logic        wb_dmem_stb_i,
  input  logic        wb_dmem_we_i,
  input  logic [3:0]  wb_dmem_be_i,
  input  logic [31:0] wb_dmem_adr_i,
  input  logic [31:0] wb_dmem_dat_i,
  output logic [31:0] wb_dmem_dat_o,
  output logic        wb_dmem_ack_o,
  output logic        wb_mem_cyc_o,
  output logic        wb_mem_stb_o,
  output logic        wb_mem_we_o,
  output logic [3:0]  wb_mem_be_o,
  output logic [31:0] wb_mem_adr_o,
  output logic [31:0] wb_mem_dat_o,
  input  logic [31:0] wb_mem_dat_i,
  input  logic        wb_mem_ack_i,
  output logic        timeout_o
);

  arb_state_t state_r, state_s;
  logic       last_dmem_r, last_dmem_s;
  logic       req_i_s, req_d_s;
  logic       gnt_i_s, gnt_d_s;
  logic       live_s, ack_s, expire_s, to_s;

  // Request decode and grant qualification; a master dropping cyc kills its grant at once.
  always_comb begin
    req_i_s = wb_imem_cyc_i & wb_imem_stb_i;
    req_d_s = wb_dmem_cyc_i & wb_dmem_stb_i;
    gnt_i_s = (state_r == GNT_I);
    gnt_d_s = (state_r == GNT_D);
    if (gnt_i_s) begin
      live_s = wb_imem_cyc_i;
    end else if (gnt_d_s) begin
      live_s = wb_dmem_cyc_i;
    end else begin
      live_s = 1'b0;
    end
    ack_s = live_s & wb_mem_ack_i;
    // A genuine ack in the expiry cycle takes precedence over the timeout.
    to_s  = live_s & expire_s & ~wb_mem_ack_i;
  end

  frv_wb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .clr    (state_r == IDLE),
    .en     (live_s),
    .expire (expire_s)
  );

  // State and fairness registers.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= IDLE;
      last_dmem_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_dmem_r <= last_dmem_s;
    end
  end

  // Next-state logic; every exit from a grant passes through IDLE, forcing a bus idle cycle.
  always_comb begin
    state_s     = state_r;
    last_dmem_s = last_dmem_r;
    case (state_r)
      IDLE: begin
        state_s = pick_grant(req_i_s, req_d_s, last_dmem_r);
      end
      GNT_I: begin
        if (!wb_imem_cyc_i) begin
          state_s = IDLE;
        end else if (ack_s || to_s) begin
          state_s     = IDLE;
          last_dmem_s = 1'b0;
        end else begin
          state_s = GNT_I;
        end
      end
      GNT_D: begin
        if (!wb_dmem_cyc_i) begin
          state_s = IDLE;
        end else if (ack_s || to_s) begin
          state_s     = IDLE;
          last_dmem_s = 1'b1;
        end else begin
          state_s = GNT_D;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Shared-bus and return-path muxes; everything reads zero while no live grant exists.
  always_comb begin
    wb_mem_cyc_o  = 1'b0;
    wb_mem_stb_o  = 1'b0;
    wb_mem_we_o   = 1'b0;
    wb_mem_be_o   = 4'h0;
    wb_mem_adr_o  = 32'h0000_0000;
    wb_mem_dat_o  = 32'h0000_0000;
    wb_imem_dat_o = 32'h0000_0000;
    wb_imem_ack_o = 1'b0;
    wb_dmem_dat_o = 32'h0000_0000;
    wb_dmem_ack_o = 1'b0;
    timeout_o     = to_s;
    if (live_s) begin
      wb_mem_cyc_o  = ~to_s;
      wb_mem_stb_o  = ~to_s;
      wb_imem_dat_o = wb_mem_dat_i;
      wb_dmem_dat_o = wb_mem_dat_i;
      if (gnt_d_s) begin
        wb_mem_we_o   = wb_dmem_we_i;
        wb_mem_be_o   = wb_dmem_be_i;
        wb_mem_adr_o  = wb_dmem_adr_i;
        wb_mem_dat_o  = wb_dmem_dat_i;
        wb_dmem_ack_o = ack_s | to_s;
        wb_dmem_dat_o = to_s ? ERR_DATA : wb_mem_dat_i;
      end else begin
        wb_mem_be_o   = IMEM_BE;
        wb_mem_adr_o  = wb_imem_adr_i;
        wb_imem_ack_o = ack_s | to_s;
        wb_imem_dat_o = to_s ? ERR_DATA : wb_mem_dat_i;
      end
    end else begin
      timeout_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_frv_wb_arb.sv
// Self-checking bench for frv_wb_arb: randomized traffic against a transfer-level
// model of the arbitration order, latency, watchdog and reset/abort behaviour.
module tb_frv_wb_arb;

  localparam int unsigned TO = 4;
  localparam logic [31:0] ERR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cyc, i_stb, d_cyc, d_stb, d_we, m_ack;
  logic [31:0] i_adr, d_adr, d_wdat, m_rdat;
  logic [3:0]  d_be;
  logic [31:0] i_dat, d_dat, b_adr, b_dat;
  logic        i_ack, d_ack, b_cyc, b_stb, b_we, tmo;
  logic [3:0]  b_be;
  logic [137:0] outs;
  logic [70:0]  bus;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign outs = {b_cyc, b_stb, b_we, b_be, b_adr, b_dat, i_dat, i_ack, d_dat, d_ack, tmo};
  assign bus  = {b_cyc, b_stb, b_we, b_be, b_adr, b_dat};

  frv_wb_arb #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk_i(clk), .rst_in(rst_n),
    .wb_imem_cyc_i(i_cyc), .wb_imem_stb_i(i_stb), .wb_imem_adr_i(i_adr),
    .wb_imem_dat_o(i_dat), .wb_imem_ack_o(i_ack),
    .wb_dmem_cyc_i(d_cyc), .wb_dmem_stb_i(d_stb), .wb_dmem_we_i(d_we),
    .wb_dmem_be_i(d_be), .wb_dmem_adr_i(d_adr), .wb_dmem_dat_i(d_wdat),
    .wb_dmem_dat_o(d_dat), .wb_dmem_ack_o(d_ack),
    .wb_mem_cyc_o(b_cyc), .wb_mem_stb_o(b_stb), .wb_mem_we_o(b_we),
    .wb_mem_be_o(b_be), .wb_mem_adr_o(b_adr), .wb_mem_dat_o(b_dat),
    .wb_mem_dat_i(m_rdat), .wb_mem_ack_i(m_ack), .timeout_o(tmo)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = $urandom;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_be = 4'hF; d_adr = $urandom; d_wdat = $urandom;
    m_ack = 1'b1; m_rdat = $urandom | 32'h1;
    repeat (2) begin
      @(negedge clk); #1;
      n_vec++;
      if (outs !== 138'h0) begin
        n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
    end
    @(negedge clk);
    i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; m_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_imem_read();
    logic [70:0] exp_bus;
    @(negedge clk);
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0040; #1;
    n_vec++;
    if (b_cyc !== 1'b0) begin n_err++; $display("FAIL imem_latency: cyc %b want 0", b_cyc); end
    exp_bus = {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0};
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      m_ack = (k == 3); m_rdat = (k == 3) ? 32'h0000_0093 : $urandom; #1;
      n_vec++;
      if (bus !== exp_bus) begin n_err++; $display("FAIL imem_bus k=%0d: got %h want %h", k, bus, exp_bus); end
      n_vec++;
      if ({i_ack, d_ack, tmo} !== {(k == 3), 1'b0, 1'b0}) begin
        n_err++; $display("FAIL imem_ack k=%0d: got %b", k, {i_ack, d_ack, tmo});
      end
      if (k == 3) begin
        n_vec++;
        if (i_dat !== 32'h0000_0093) begin n_err++; $display("FAIL imem_data: got %h want 00000093", i_dat); end
      end
    end
    @(negedge clk);
    i_cyc = 1'b0; i_stb = 1'b0; m_ack = 1'b0; #1;
    n_vec++;
    if ({b_cyc, i_ack} !== 2'b00) begin n_err++; $display("FAIL imem_end: cyc/ack %b want 00", {b_cyc, i_ack}); end
  endtask

  // Both masters request continuously from reset; the model expects D first, then strict alternation.
  task automatic test_contention(input int n_xfer, input bit fixed_first);
    logic [70:0] exp_bus;
    logic [31:0] rd;
    bit          exp_d;
    int          lat;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    i_adr = $urandom;
    if (fixed_first) begin
      d_we = 1'b1; d_be = 4'h3; d_adr = 32'h0000_0100; d_wdat = 32'hDEAD_BEEF;
    end else begin
      d_we = 1'($urandom); d_be = 4'($urandom); d_adr = $urandom; d_wdat = $urandom;
    end
    @(negedge clk);
    i_cyc = 1'b1; i_stb = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; #1;
    n_vec++;
    if (b_cyc !== 1'b0) begin n_err++; $display("FAIL contend_latency: cyc %b want 0", b_cyc); end
    for (int j = 0; j < n_xfer; j++) begin
      exp_d = (j % 2 == 0);
      lat = $urandom_range(1, 3);
      exp_bus = exp_d ? {1'b1, 1'b1, d_we, d_be, d_adr, d_wdat}
                      : {1'b1, 1'b1, 1'b0, 4'hF, i_adr, 32'h0};
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        rd = $urandom; m_ack = (k == lat); m_rdat = rd; #1;
        n_vec++;
        if (bus !== exp_bus) begin
          n_err++; $display("FAIL contend_bus x%0d k%0d: got %h want %h", j, k, bus, exp_bus);
        end
        n_vec++;
        if ({i_ack, d_ack, tmo} !== {(k == lat) && !exp_d, (k == lat) && exp_d, 1'b0}) begin
          n_err++; $display("FAIL contend_ack x%0d k%0d: got %b dmem_expected=%0d", j, k, {i_ack, d_ack, tmo}, exp_d);
        end
        if (k == lat) begin
          n_vec++;
          if ((exp_d ? d_dat : i_dat) !== rd) begin
            n_err++; $display("FAIL contend_data x%0d: got %h want %h", j, exp_d ? d_dat : i_dat, rd);
          end
        end
      end
      @(negedge clk);
      m_ack = 1'b0;
      if (exp_d) begin
        d_we = 1'($urandom); d_be = 4'($urandom); d_adr = $urandom; d_wdat = $urandom;
      end else begin
        i_adr = $urandom;
      end
      if (j == n_xfer - 1) begin
        i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
      end
      #1;
      n_vec++;
      if ({b_cyc, i_ack, d_ack} !== 3'b000) begin
        n_err++; $display("FAIL contend_gap x%0d: cyc/acks %b want 000", j, {b_cyc, i_ack, d_ack});
      end
    end
  endtask

  // dmem read with a silent slave, optionally acking exactly in the expiry cycle.
  task automatic test_watchdog(input bit ack_at_expiry);
    logic [31:0] rd;
    logic [31:0] exp_d;
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_be = 4'hF; d_adr = $urandom; #1;
    n_vec++;
    if (b_cyc !== 1'b0) begin n_err++; $display("FAIL wdog_latency: cyc %b want 0", b_cyc); end
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      rd = (ack_at_expiry && k == int'(TO)) ? 32'hA5A5_A5A5 : $urandom;
      m_ack = ack_at_expiry && (k == int'(TO)); m_rdat = rd; #1;
      n_vec++;
      if (k < int'(TO)) begin
        if ({b_cyc, b_stb, b_adr, d_ack, tmo} !== {2'b11, d_adr, 2'b00}) begin
          n_err++; $display("FAIL wdog_wait k%0d: got cyc%b stb%b ack%b to%b", k, b_cyc, b_stb, d_ack, tmo);
        end
      end else begin
        exp_d = ack_at_expiry ? 32'hA5A5_A5A5 : ERR;
        if ({b_cyc, b_stb, d_ack, i_ack, tmo, d_dat} !==
            {ack_at_expiry, ack_at_expiry, 1'b1, 1'b0, !ack_at_expiry, exp_d}) begin
          n_err++; $display("FAIL wdog_expiry ack_in=%0d: got cyc%b stb%b dack%b iack%b to%b dat %h want dat %h",
                            ack_at_expiry, b_cyc, b_stb, d_ack, i_ack, tmo, d_dat, exp_d);
        end
      end
    end
    @(negedge clk);
    m_ack = 1'b0; #1;
    n_vec++;
    if ({b_cyc, d_ack, tmo} !== 3'b000) begin
      n_err++; $display("FAIL wdog_after: cyc/ack/to %b want 000", {b_cyc, d_ack, tmo});
    end
    d_cyc = 1'b0; d_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_be = 4'hF; d_adr = $urandom; m_rdat = $urandom | 32'h1; #1;
    @(negedge clk); #1;
    n_vec++;
    if ({b_cyc, b_adr} !== {1'b1, d_adr}) begin n_err++; $display("FAIL abort_pre_grant: cyc %b adr %h", b_cyc, b_adr); end
    #2 rst_n = 1'b0; #1;
    n_vec++;
    if (outs !== 138'h0) begin n_err++; $display("FAIL async_reset: got %h want 0", outs); end
    @(negedge clk);
    d_cyc = 1'b0; d_stb = 1'b0; #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      m_ack = 1'b1; m_rdat = $urandom; #1;
      n_vec++;
      if (outs !== 138'h0) begin n_err++; $display("FAIL stray_ack: got %h want 0", outs); end
    end
    @(negedge clk);
    m_ack = 1'b0; i_cyc = 1'b1; i_stb = 1'b1; i_adr = $urandom; #1;
    @(negedge clk); #1;
    n_vec++;
    if ({b_cyc, b_adr} !== {1'b1, i_adr}) begin n_err++; $display("FAIL abort_grant: cyc %b adr %h want %h", b_cyc, b_adr, i_adr); end
    @(negedge clk);
    i_cyc = 1'b0; #1;
    n_vec++;
    if ({b_cyc, b_stb, i_ack, d_ack} !== 4'b0000) begin
      n_err++; $display("FAIL abort_drop: cyc/stb/acks %b want 0000", {b_cyc, b_stb, i_ack, d_ack});
    end
    i_stb = 1'b0;
    @(negedge clk);
    d_cyc = 1'b1; d_stb = 1'b1; d_adr = $urandom; #1;
    @(negedge clk); #1;
    n_vec++;
    if ({b_cyc, b_adr, i_ack} !== {1'b1, d_adr, 1'b0}) begin
      n_err++; $display("FAIL abort_idle: cyc %b adr %h want %h", b_cyc, b_adr, d_adr);
    end
    @(negedge clk);
    d_cyc = 1'b0; d_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_imem_read();
    test_contention(2, 1'b1);
    test_contention(6, 1'b0);
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
